// File: rtl/ram_rmw_accum_pkg.sv
// ram_rmw_accum_pkg: FSM states and RAM port-A read latency shared by port-A clients
package ram_rmw_accum_pkg;
    typedef enum logic [1:0] {IDLE, RD1, RD2, WR} rmw_state_e;
    localparam int RAM_PORTA_RD_LAT = 2;
endpackage

// File: rtl/ram_rmw_accum_rmw_adder.sv
// ram_rmw_accum_rmw_adder: word + zero-extended increment; saturates when RMW_ACCUM_SAT_EN is defined, else wraps
module ram_rmw_accum_rmw_adder #(
    parameter int DATA_WIDTH = 16,
    parameter int INC_WIDTH  = 8
) (
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [INC_WIDTH-1:0]  inc,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  carry
);
    logic [DATA_WIDTH:0] sum;
    assign sum   = {1'b0, word} + {{(DATA_WIDTH-INC_WIDTH+1){1'b0}}, inc};
    assign carry = sum[DATA_WIDTH];
`ifdef RMW_ACCUM_SAT_EN
    assign result = carry ? '1 : sum[DATA_WIDTH-1:0];
`else
    assign result = sum[DATA_WIDTH-1:0];
`endif
endmodule

// File: rtl/ram_rmw_accum.sv
// ram_rmw_accum: per-address read-modify-write accumulator driving RAM port A (RMW_ACCUM_SAT_EN selects saturation)
module ram_rmw_accum
    import ram_rmw_accum_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int INC_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [INC_WIDTH-1:0]  in_inc,
    input  logic                  ram_ready,
    output logic                  ram_write,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic                  ovf,
    output logic                  drop,
    output logic                  busy
);
    rmw_state_e            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [INC_WIDTH-1:0]  inc_q;
    logic [DATA_WIDTH-1:0] res_q;
    logic [DATA_WIDTH-1:0] result;
    logic                  carry;
    logic                  accept;

    ram_rmw_accum_rmw_adder #(.DATA_WIDTH(DATA_WIDTH), .INC_WIDTH(INC_WIDTH)) u_add (
        .word(ram_q), .inc(inc_q), .result(result), .carry(carry)
    );

    assign in_ready = (state == IDLE) && ram_ready && !rst;
    assign accept   = in_valid && in_ready;
    // the read address goes out in the accept cycle so ram_q lands in RD2
    assign ram_addr = accept ? in_addr : addr_q;
    assign ram_data = res_q;
    assign busy     = state != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            inc_q     <= '0;
            res_q     <= '0;
            ram_write <= 1'b0;
            ovf       <= 1'b0;
            drop      <= 1'b0;
        end else begin
            ram_write <= 1'b0;
            ovf       <= 1'b0;
            drop      <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    addr_q <= in_addr;
                    inc_q  <= in_inc;
                    state  <= RD1;
                end
                RD1: begin
                    state <= ram_ready ? RD2 : IDLE;
                    drop  <= !ram_ready;
                end
                RD2: if (ram_ready) begin
                    res_q     <= result;
                    ovf       <= carry;
                    ram_write <= 1'b1;
                    state     <= WR;
                end else begin
                    drop  <= 1'b1;
                    state <= IDLE;
                end
                WR: begin
                    drop  <= !ram_ready;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_rmw_accum.sv
// tb_ram_rmw_accum: randomized scoreboard bench with a latency-2 port-A RAM model and a per-word reference
module tb_ram_rmw_accum;
`ifdef RMW_ACCUM_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    typedef struct {logic [3:0] a; logic [15:0] d; logic o; int c;} exp_t;

    logic        clk = 0, rst = 1, in_valid = 0, ram_ready = 0;
    logic [3:0]  in_addr = 0;
    logic [7:0]  in_inc = 0;
    logic        in_ready, ram_write, ovf, drop, busy;
    logic [3:0]  ram_addr;
    logic [15:0] ram_data, ram_q;

    logic [15:0] mem [16];
    logic [15:0] ref_mem [16];
    logic [3:0]  a1, wa1, pre_a = 0;
    logic [15:0] wd1, pre_v = 0;
    logic        we1 = 0, clr_req = 1, pre_req = 0, no_expect = 0;
    exp_t        sb[$];
    int          compared = 0, mismatched = 0, cyc = 0, writes = 0, drops = 0, ovfs = 0;

    ram_rmw_accum dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_inc(in_inc), .ram_ready(ram_ready), .ram_write(ram_write), .ram_addr(ram_addr),
        .ram_data(ram_data), .ram_q(ram_q), .ovf(ovf), .drop(drop), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // port-A RAM: read data 2 cycles after address, write committed 2 edges after issue
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (we1) mem[wa1] = wd1;
        if (clr_req) for (int i = 0; i < 16; i++) mem[i] = '0;
        if (pre_req) mem[pre_a] = pre_v;
        we1   <= ram_write;
        wa1   <= ram_addr;
        wd1   <= ram_data;
        a1    <= ram_addr;
        ram_q <= mem[a1];
    end

    // reference model and scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        int unsigned s;
        if (clr_req) for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        if (pre_req) ref_mem[pre_a] = pre_v;
        if (in_valid && in_ready && !no_expect) begin
            s   = ref_mem[in_addr] + in_inc;
            e.a = in_addr;
            e.o = s > 32'hFFFF;
            e.d = (e.o && SAT) ? 16'hFFFF : 16'(s);
            e.c = cyc;
            ref_mem[in_addr] = e.d;
            sb.push_back(e);
        end
        if (drop) drops++;
        if (ovf) ovfs++;
        if (ram_write) begin
            writes++;
            if (sb.size() == 0) chk("unexpected_write", 1, 0);
            else begin
                e = sb.pop_front();
                chk("wr_addr", ram_addr, e.a);
                chk("wr_data", ram_data, e.d);
                chk("wr_ovf", ovf, e.o);
                chk("wr_latency", cyc - e.c, 3);
            end
        end else if (ovf) chk("ovf_without_write", ovf, 0);
    end

    task automatic accept_one(input logic [3:0] a, input logic [7:0] i, output int waited);
        in_valid = 1; in_addr = a; in_inc = i; waited = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            if (++waited > 100) begin
                chk("accept_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic send(input logic [3:0] a, input logic [7:0] i);
        int w;
        accept_one(a, i, w);
        @(posedge clk); #1 in_valid = 0;
        repeat (3) begin
            @(negedge clk);
            chk("in_ready_hold", in_ready, 0);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
        chk("drain_empty", sb.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int w, w0, d0, o0;
        in_valid = 1; in_addr = 3; in_inc = 5;
        repeat (3) begin @(negedge clk); chk("rst_in_ready", in_ready, 0); end
        @(posedge clk); #1 rst = 0; clr_req = 0;
        @(negedge clk);
        chk("rst_ram_write", ram_write, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_data", ram_data, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_drop", drop, 0);
        chk("rst_busy", busy, 0);
        repeat (5) begin
            @(negedge clk);
            chk("notready_in_ready", in_ready, 0);
            chk("notready_write", ram_write, 0);
        end
        @(posedge clk); #1 ram_ready = 1;
        accept_one(3, 5, w);
        chk("first_ready_accept_wait", w, 0);
        @(posedge clk); #1 in_valid = 0;
        repeat (3) begin @(negedge clk); chk("in_ready_hold", in_ready, 0); end
        send(3, 7);
        drain();
        chk("word3_sum", mem[3], 12);

        @(posedge clk); #1 pre_req = 1; pre_a = 7; pre_v = 16'hFFF0;
        @(posedge clk); #1 pre_req = 0;
        o0 = ovfs;
        send(7, 8'h20);
        drain();
        chk("word7_overflow", mem[7], SAT ? 16'hFFFF : 16'h0010);
        chk("ovf_pulse_count", ovfs - o0, 1);

        w0 = writes;
        for (int k = 0; k < 40; k++) begin
            logic [3:0] a;
            logic [7:0] i;
            a = ($urandom_range(0, 3) == 0) ? 4'($urandom) : (($urandom_range(0, 2) == 0) ? 4'd0 : (($urandom_range(0, 1) == 0) ? 4'd1 : 4'd15));
            i = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1 send(a, i);
        end
        drain();
        chk("random_write_count", writes - w0, 40);
        for (int k = 0; k < 16; k++) chk("word_vs_model", mem[k], ref_mem[k]);

        no_expect = 1; d0 = drops; w0 = writes;
        @(posedge clk); #1;
        accept_one(5, 9, w);
        @(posedge clk); #1 in_valid = 0;
        @(posedge clk); #1 ram_ready = 0; clr_req = 1;
        @(posedge clk); #1 clr_req = 0; in_valid = 1; in_addr = 2; in_inc = 1;
        repeat (4) begin
            @(negedge clk);
            chk("abort_in_ready_low", in_ready, 0);
            chk("abort_busy", busy, 0);
        end
        chk("abort_drop_count", drops - d0, 1);
        chk("abort_no_write", writes - w0, 0);
        for (int k = 0; k < 16; k++) chk("abort_word_zero", mem[k], 0);
        @(posedge clk); #1 in_valid = 0; ram_ready = 1;

        d0 = drops; w0 = writes; o0 = ovfs;
        @(posedge clk); #1;
        accept_one(6, 3, w);
        @(posedge clk); #1 in_valid = 0;
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("rst_rd2_busy", busy, 0);
        chk("rst_rd2_write", ram_write, 0);
        repeat (4) @(negedge clk);
        chk("rst_rd2_no_write", writes - w0, 0);
        chk("rst_rd2_no_drop", drops - d0, 0);
        chk("rst_rd2_no_ovf", ovfs - o0, 0);
        no_expect = 0;

        for (int k = 0; k < 10; k++) send(4'($urandom), 8'($urandom));
        drain();
        for (int k = 0; k < 16; k++) chk("final_word_vs_model", mem[k], ref_mem[k]);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
